// File: rtl/serial_add_ctrl.sv
// Bit-serial add sequencer: drives an external 1-bit full-adder cell LSB-first,
// one bit per clock, and returns the WIDTH-bit sum with carry and signed overflow.
module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             carry_i,
   output logic             ready_o,
   output logic             fa_a_o,
   output logic             fa_b_o,
   output logic             fa_c_o,
   input  logic             fa_sum_i,
   input  logic             fa_carry_i,
   output logic             valid_o,
   input  logic             ack_i,
   output logic [WIDTH-1:0] sum_o,
   output logic             carry_o,
   output logic             overflow_o
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_a_sh;
   logic [WIDTH-1:0] r_b_sh;
   logic [WIDTH-1:0] r_res;
   logic [WIDTH-1:0] r_sum;
   logic             r_carry;
   logic             r_carry_out;
   logic             r_ovf;
   logic             r_ready;
   logic             r_valid;
   logic [CW-1:0]    r_cnt;

   logic             w_run;
   logic [WIDTH-1:0] w_res_next;

   assign w_run      = (r_state == S_RUN);
   assign w_res_next = {fa_sum_i, r_res[WIDTH-1:1]};

   // Cell inputs are forced low outside RUN so the cell sees no stray activity.
   assign fa_a_o     = w_run & r_a_sh[0];
   assign fa_b_o     = w_run & r_b_sh[0];
   assign fa_c_o     = w_run & r_carry;

   assign ready_o    = r_ready;
   assign valid_o    = r_valid;
   assign sum_o      = r_sum;
   assign carry_o    = r_carry_out;
   assign overflow_o = r_ovf;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= S_IDLE;
         r_ready     <= 1'b1;
         r_valid     <= 1'b0;
         r_a_sh      <= '0;
         r_b_sh      <= '0;
         r_res       <= '0;
         r_sum       <= '0;
         r_carry     <= 1'b0;
         r_carry_out <= 1'b0;
         r_ovf       <= 1'b0;
         r_cnt       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start_i) begin
                  r_a_sh  <= a_i;
                  r_b_sh  <= b_i;
                  r_carry <= carry_i;
                  r_cnt   <= '0;
                  r_ready <= 1'b0;
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               r_res   <= w_res_next;
               r_a_sh  <= r_a_sh >> 1;
               r_b_sh  <= r_b_sh >> 1;
               r_carry <= fa_carry_i;
               r_cnt   <= r_cnt + 1'b1;
               // MSB cycle: r_carry is the carry into the MSB, fa_carry_i the carry out.
               if (r_cnt == LAST_BIT) begin
                  r_sum       <= w_res_next;
                  r_carry_out <= fa_carry_i;
                  r_ovf       <= r_carry ^ fa_carry_i;
                  r_valid     <= 1'b1;
                  r_state     <= S_DONE;
               end
            end
            S_DONE: begin
               if (ack_i) begin
                  r_valid <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_valid <= 1'b0;
               r_ready <= 1'b1;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl with an ideal full-adder cell model;
// expected results travel through a scoreboard queue from stimulus to output.
module tb_serial_add_ctrl;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst_i;
   logic             start_i;
   logic [WIDTH-1:0] a_i;
   logic [WIDTH-1:0] b_i;
   logic             carry_i;
   logic             ready_o;
   logic             fa_a_o;
   logic             fa_b_o;
   logic             fa_c_o;
   logic             fa_sum_i;
   logic             fa_carry_i;
   logic             valid_o;
   logic             ack_i;
   logic [WIDTH-1:0] sum_o;
   logic             carry_o;
   logic             overflow_o;

   serial_add_ctrl #(.WIDTH(WIDTH)) dut (
      .clk_i      (clk),
      .rst_i      (rst_i),
      .start_i    (start_i),
      .a_i        (a_i),
      .b_i        (b_i),
      .carry_i    (carry_i),
      .ready_o    (ready_o),
      .fa_a_o     (fa_a_o),
      .fa_b_o     (fa_b_o),
      .fa_c_o     (fa_c_o),
      .fa_sum_i   (fa_sum_i),
      .fa_carry_i (fa_carry_i),
      .valid_o    (valid_o),
      .ack_i      (ack_i),
      .sum_o      (sum_o),
      .carry_o    (carry_o),
      .overflow_o (overflow_o)
   );

   always #5 clk = ~clk;

   // Ideal combinational full-adder cell
   assign fa_sum_i   = fa_a_o ^ fa_b_o ^ fa_c_o;
   assign fa_carry_i = (fa_a_o & fa_b_o) | (fa_c_o & (fa_a_o ^ fa_b_o));

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [WIDTH-1:0] sum;
      logic             carry;
      logic             ovf;
   } exp_t;

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic             cin;
      logic [WIDTH-1:0] sum;
      logic             carry;
      logic             ovf;
   } vec_t;

   exp_t sb_q[$];
   vec_t vecs[7];
   int   n_checks = 0;
   int   n_pass   = 0;
   int   acc_cyc  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
   endtask

   function automatic exp_t ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                    input logic c);
      exp_t         r;
      logic [WIDTH:0] t;
      t       = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
      r.sum   = t[WIDTH-1:0];
      r.carry = t[WIDTH];
      r.ovf   = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
      return r;
   endfunction

   function automatic exp_t mk_exp(input logic [WIDTH-1:0] s, input logic c, input logic o);
      exp_t r;
      r.sum   = s;
      r.carry = c;
      r.ovf   = o;
      return r;
   endfunction

   // Called at a negedge; presents one request and returns one cycle after accept.
   task automatic op_start(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic c, input exp_t e);
      int n = 0;
      while (ready_o !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("ready_before_start", 32'(ready_o), 32'd1);
      sb_q.push_back(e);
      a_i     = x;
      b_i     = y;
      carry_i = c;
      start_i = 1'b1;
      acc_cyc = cyc;
      @(negedge clk);
      start_i = 1'b0;
      check("ready_low_in_run", 32'(ready_o), 32'd0);
   endtask

   // Waits for the result, scores it, optionally stalls ack for 'hold' cycles, then acks.
   task automatic op_finish(input int hold);
      int               n = 0;
      exp_t             e;
      logic [WIDTH-1:0] held;
      while (valid_o !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      check("latency", 32'(cyc - acc_cyc), 32'(WIDTH + 1));
      if (sb_q.size() == 0) begin
         check("scoreboard_nonempty", 32'd0, 32'd1);
         e = '0;
      end else begin
         e = sb_q.pop_front();
      end
      $display("op: sum=0x%02h carry=%0b ovf=%0b (expected 0x%02h %0b %0b)",
               sum_o, carry_o, overflow_o, e.sum, e.carry, e.ovf);
      check("sum", 32'(sum_o), 32'(e.sum));
      check("carry", 32'(carry_o), 32'(e.carry));
      check("overflow", 32'(overflow_o), 32'(e.ovf));
      held = sum_o;
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin
            a_i     = 8'h11;
            start_i = 1'b1;
         end else begin
            start_i = 1'b0;
         end
         @(negedge clk);
         check("hold_valid", 32'(valid_o), 32'd1);
         check("hold_sum", 32'(sum_o), 32'(held));
         check("fa_zero_in_done", 32'({fa_a_o, fa_b_o, fa_c_o}), 32'd0);
      end
      start_i = 1'b0;
      ack_i   = 1'b1;
      @(negedge clk);
      ack_i   = 1'b0;
      check("valid_drop_after_ack", 32'(valid_o), 32'd0);
      check("ready_after_ack", 32'(ready_o), 32'd1);
   endtask

   initial begin
      int            done;
      int            issued;
      int            budget;
      int            last_acc;
      exp_t          e;
      logic [WIDTH-1:0] rx;
      logic [WIDTH-1:0] ry;
      logic          rc;

      vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[5] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      vecs[6] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};

      rst_i   = 1'b1;
      start_i = 1'b0;
      ack_i   = 1'b0;
      a_i     = '0;
      b_i     = '0;
      carry_i = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_ready", 32'(ready_o), 32'd1);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_sum", 32'(sum_o), 32'd0);
      check("rst_carry_ovf", 32'({carry_o, overflow_o}), 32'd0);
      check("rst_fa", 32'({fa_a_o, fa_b_o, fa_c_o}), 32'd0);
      rst_i = 1'b0;
      @(negedge clk);

      // Table-driven single operations
      for (int i = 0; i < 7; i++) begin
         op_start(vecs[i].a, vecs[i].b, vecs[i].cin,
                  mk_exp(vecs[i].sum, vecs[i].carry, vecs[i].ovf));
         op_finish(0);
      end

      // start pulses during RUN and DONE are ignored; ack stalled 5 cycles
      op_start(8'h5A, 8'h3C, 1'b0, mk_exp(8'h96, 1'b0, 1'b1));
      a_i     = 8'h11;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
      check("ready_low_start_in_run", 32'(ready_o), 32'd0);
      op_finish(5);
      repeat (3) @(negedge clk);
      check("no_queued_op_ready", 32'(ready_o), 32'd1);
      check("no_queued_op_valid", 32'(valid_o), 32'd0);
      check("fa_zero_in_idle", 32'({fa_a_o, fa_b_o, fa_c_o}), 32'd0);

      // Reset after the 4th RUN cycle aborts the operation
      op_start(8'hC3, 8'h5A, 1'b1, mk_exp(8'h1E, 1'b1, 1'b0));
      repeat (4) @(negedge clk);
      rst_i = 1'b1;
      @(negedge clk);
      rst_i = 1'b0;
      sb_q.delete();
      check("abort_ready", 32'(ready_o), 32'd1);
      check("abort_valid", 32'(valid_o), 32'd0);
      check("abort_sum", 32'(sum_o), 32'd0);
      repeat (12) @(negedge clk);
      check("abort_no_late_valid", 32'(valid_o), 32'd0);
      op_start(8'h10, 8'h20, 1'b0, mk_exp(8'h30, 1'b0, 1'b0));
      op_finish(0);

      // Back-to-back random operations with ack tied high
      done     = 0;
      issued   = 0;
      budget   = 0;
      last_acc = 0;
      ack_i    = 1'b1;
      while (done < 1000 && budget < 15000) begin
         @(negedge clk);
         budget++;
         if (valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
               check("b2b_scoreboard_nonempty", 32'd0, 32'd1);
            end else begin
               e = sb_q.pop_front();
               check("b2b_sum", 32'(sum_o), 32'(e.sum));
               check("b2b_carry", 32'(carry_o), 32'(e.carry));
               check("b2b_overflow", 32'(overflow_o), 32'(e.ovf));
            end
            done++;
         end
         if (ready_o === 1'b1 && issued < 1000) begin
            rx = WIDTH'($urandom);
            ry = WIDTH'($urandom);
            rc = 1'($urandom);
            sb_q.push_back(ref_add(rx, ry, rc));
            a_i     = rx;
            b_i     = ry;
            carry_i = rc;
            start_i = 1'b1;
            if (issued > 0) check("b2b_period", 32'(cyc - last_acc), 32'(WIDTH + 2));
            last_acc = cyc;
            issued++;
         end
      end
      start_i = 1'b0;
      if (done < 1000) check("b2b_completed", 32'(done), 32'd1000);
      $display("back-to-back: %0d ops issued, %0d results scored", issued, done);
      @(negedge clk);
      ack_i = 1'b0;
      check("final_ready", 32'(ready_o), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
